// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Fetch-stage types and constants shared by the PC register,
//                the IF/ID buffer and decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int FETCH_W = 32;

    localparam logic [FETCH_W-1:0] PC_INCR  = 32'd4;
    localparam logic [FETCH_W-1:0] RESET_PC = 32'd0;

    typedef struct packed {
        logic [FETCH_W-1:0] pc;
        logic [FETCH_W-1:0] pc_plus4;
        logic [FETCH_W-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, pc_plus4: '0, instr: '0};

endpackage

`default_nettype wire

// File: rtl/if_id_buffer_if.sv
// ============================================================================
//  Module      : if_id_buffer_if
//  Description : Fetch-side and decode-side valid/ready bundle of the IF/ID
//                buffer. master = stimulus/fetch+decode, slave = buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_id_buffer_if #(
    parameter int AW = 32
);
    logic [AW-1:0] InPC;
    logic [AW-1:0] InInstr;
    logic          InValid;
    logic          InReady;
    logic [AW-1:0] OutPC;
    logic [AW-1:0] OutPCPlus4;
    logic [AW-1:0] OutInstr;
    logic          OutValid;
    logic          OutReady;

    modport master (
        output InPC, InInstr, InValid, OutReady,
        input  InReady, OutPC, OutPCPlus4, OutInstr, OutValid
    );

    modport slave (
        input  InPC, InInstr, InValid, OutReady,
        output InReady, OutPC, OutPCPlus4, OutInstr, OutValid
    );
endinterface

`default_nettype wire

// File: rtl/if_id_fifo_mem.sv
// ============================================================================
//  Module      : if_id_fifo_mem
//  Description : DEPTH x fetch_entry_t storage, one write and one
//                asynchronous read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_fifo_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  wire logic         Clk,
    input  wire logic         we,
    input  wire logic [PW-1:0] waddr,
    input  wire fetch_entry_t wdata,
    input  wire logic [PW-1:0] raddr,
    output fetch_entry_t      rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ============================================================================
//  Module      : if_id_buffer
//  Description : IF/ID decoupling FIFO with valid/ready handshake and flush.
//                Optional IFID_STATS_EN adds StallCount / FlushCount outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  wire logic  Clk,
    input  wire logic  Reset,
    input  wire logic  Flush,
    if_id_buffer_if.slave bus
`ifdef IFID_STATS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int           PW         = $clog2(DEPTH);
    localparam logic [PW:0]  FULL_COUNT = DEPTH[PW:0];

    logic [PW:0]   r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_valid;
    fetch_entry_t  r_head;

    logic          w_push;
    logic          w_pop;
    logic [PW:0]   w_remain;
    logic [PW:0]   w_next_count;
    logic [PW-1:0] w_next_rd;
    logic [AW-1:0] w_pc_plus4;
    fetch_entry_t  w_in_entry;
    fetch_entry_t  w_mem_rdata;

    assign bus.InReady    = (r_count != FULL_COUNT);
    assign bus.OutValid   = r_valid;
    assign bus.OutPC      = r_head.pc;
    assign bus.OutPCPlus4 = r_head.pc_plus4;
    assign bus.OutInstr   = r_head.instr;

    assign w_push       = bus.InValid & bus.InReady;
    assign w_pop        = r_valid & bus.OutReady;
    assign w_remain     = r_count - (PW+1)'(w_pop);
    assign w_next_count = w_remain + (PW+1)'(w_push);
    assign w_next_rd    = r_rd_ptr + PW'(w_pop);
    assign w_pc_plus4   = bus.InPC + AW'(PC_INCR);

    assign w_in_entry = '{pc: bus.InPC, pc_plus4: w_pc_plus4, instr: bus.InInstr};

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .Clk   (Clk),
        .we    (w_push & ~Flush),
        .waddr (r_wr_ptr),
        .wdata (w_in_entry),
        .raddr (w_next_rd),
        .rdata (w_mem_rdata)
    );

    // The head register is preloaded with the next head entry; when nothing
    // older remains, that is the word being pushed, which the memory cannot
    // return until after this edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_head   <= RESET_ENTRY;
        end else if (Flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_count  <= w_next_count;
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= w_next_rd;
            r_valid  <= (w_next_count != '0);
            if (w_next_count != '0) begin
                r_head <= (w_remain == '0) ? w_in_entry : w_mem_rdata;
            end
        end
    end

`ifdef IFID_STATS_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (r_valid && !bus.OutReady && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
            if (Flush && (r_count != '0) && (FlushCount != 32'hFFFF_FFFF)) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Directed self-checking bench for if_id_buffer (DEPTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_buffer;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    logic Flush = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef IFID_STATS_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    if_id_buffer_if #(.AW(32)) bus ();

    if_id_buffer #(
        .DEPTH (2),
        .AW    (32)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Flush (Flush),
        .bus   (bus)
`ifdef IFID_STATS_EN
        ,
        .StallCount (StallCount),
        .FlushCount (FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.InValid = v;
        bus.InPC    = pc;
        bus.InInstr = ins;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] pc4, input logic [31:0] ins);
        check({tag, ".valid"}, 64'(bus.OutValid), 64'(v));
        check({tag, ".pc"},    64'(bus.OutPC), 64'(pc));
        check({tag, ".pc4"},   64'(bus.OutPCPlus4), 64'(pc4));
        check({tag, ".instr"}, 64'(bus.OutInstr), 64'(ins));
    endtask

    logic [31:0] exp_q[$];
    int          pushed;
    logic        m_push;
    logic        m_pop;
    logic [7:0]  rdy_pat;

    initial begin
        offer(1'b0, 32'h0, 32'h0);
        bus.OutReady = 1'b0;
        tick();
        check_out("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        check("reset.inready", 64'(bus.InReady), 64'd1);
        Reset = 1'b1;

        // Stream with one-cycle latency
        bus.OutReady = 1'b1;
        offer(1'b1, 32'h0, 32'hA);
        tick(); check_out("stream0", 1'b1, 32'h0, 32'h4, 32'hA);
        offer(1'b1, 32'h4, 32'hB);
        tick(); check_out("stream1", 1'b1, 32'h4, 32'h8, 32'hB);
        offer(1'b1, 32'h8, 32'hC);
        tick(); check_out("stream2", 1'b1, 32'h8, 32'hC, 32'hC);
        offer(1'b0, 32'h0, 32'h0);
        tick(); check_out("stream_empty", 1'b0, 32'h8, 32'hC, 32'hC);

        // Backpressure
        bus.OutReady = 1'b0;
        offer(1'b1, 32'h10, 32'h1010);
        tick(); check_out("bp0", 1'b1, 32'h10, 32'h14, 32'h1010);
        check("bp0.inready", 64'(bus.InReady), 64'd1);
        offer(1'b1, 32'h14, 32'h1414);
        tick(); check("bp1.inready", 64'(bus.InReady), 64'd0);
        check("bp1.pc", 64'(bus.OutPC), 64'h10);
        offer(1'b1, 32'h18, 32'h1818);
        tick(); check("bp2.inready", 64'(bus.InReady), 64'd0);
        check("bp2.pc", 64'(bus.OutPC), 64'h10);
        offer(1'b0, 32'h0, 32'h0);
        bus.OutReady = 1'b1;
        tick(); check_out("drain0", 1'b1, 32'h14, 32'h18, 32'h1414);
        check("drain0.inready", 64'(bus.InReady), 64'd1);
        tick(); check("drain1.valid", 64'(bus.OutValid), 64'd0);

        // Asynchronous reset with two entries held
        bus.OutReady = 1'b0;
        offer(1'b1, 32'h20, 32'h2020); tick();
        offer(1'b1, 32'h24, 32'h2424); tick();
        offer(1'b0, 32'h0, 32'h0);
        check("areset.pre_inready", 64'(bus.InReady), 64'd0);
        #2 Reset = 1'b0;
        #1;
        check_out("areset", 1'b0, 32'h0, 32'h0, 32'h0);
        check("areset.inready", 64'(bus.InReady), 64'd1);
        tick();
        Reset = 1'b1;

        // Flush with two entries and a simultaneous offer
        offer(1'b1, 32'h30, 32'h3030); tick();
        offer(1'b1, 32'h34, 32'h3434); tick();
        offer(1'b1, 32'h40, 32'h4040);
        Flush = 1'b1;
        tick(); Flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("flush2.valid", 64'(bus.OutValid), 64'd0);
        check("flush2.inready", 64'(bus.InReady), 64'd1);
        tick(); check("flush2.after", 64'(bus.OutValid), 64'd0);

        // Flush with one entry while a push would be accepted
        offer(1'b1, 32'h50, 32'h5050); tick();
        offer(1'b1, 32'h44, 32'h4444);
        Flush = 1'b1;
        tick(); Flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("flush1.valid", 64'(bus.OutValid), 64'd0);
        tick(); check("flush1.after", 64'(bus.OutValid), 64'd0);

        // PC+4 wraps modulo 2^32
        bus.OutReady = 1'b1;
        offer(1'b1, 32'hFFFF_FFFC, 32'hDEAD);
        tick(); check_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hDEAD);
        offer(1'b0, 32'h0, 32'h0);
        tick();

        // Five entries through the two-entry buffer under varying readiness
        exp_q   = {};
        pushed  = 0;
        rdy_pat = 8'b1011_0100;
        for (int c = 0; c < 16 && (pushed < 5 || exp_q.size() != 0); c++) begin
            bus.OutReady = rdy_pat[c % 8];
            offer(pushed < 5, 32'h100 + 32'(pushed) * 4, 32'hC0DE_0000 + 32'(pushed));
            m_push = (pushed < 5) && (exp_q.size() != 2);
            m_pop  = (exp_q.size() != 0) && bus.OutReady;
            tick();
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                exp_q.push_back(32'h100 + 32'(pushed) * 4);
                pushed++;
            end
            check("order.valid", 64'(bus.OutValid), 64'(exp_q.size() != 0));
            check("order.inready", 64'(bus.InReady), 64'(exp_q.size() != 2));
            if (exp_q.size() != 0) begin
                check("order.pc", 64'(bus.OutPC), 64'(exp_q[0]));
                check("order.pc4", 64'(bus.OutPCPlus4), 64'(exp_q[0] + 32'd4));
            end
        end
        check("order.all_pushed", 64'(pushed), 64'd5);
        offer(1'b0, 32'h0, 32'h0);

`ifdef IFID_STATS_EN
        Reset = 1'b0; #1;
        check("stats.reset_stall", 64'(StallCount), 64'd0);
        tick(); Reset = 1'b1;
        bus.OutReady = 1'b0;
        offer(1'b1, 32'h60, 32'h6060); tick();
        offer(1'b0, 32'h0, 32'h0);
        tick(); tick(); tick();
        check("stats.stall3", 64'(StallCount), 64'd3);
        bus.OutReady = 1'b1;
        Flush = 1'b1;
        tick();
        check("stats.flush1", 64'(FlushCount), 64'd1);
        tick(); Flush = 1'b0;
        check("stats.flush_empty", 64'(FlushCount), 64'd1);
        check("stats.stall_final", 64'(StallCount), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
